// File: rtl/fixpoint_pkg.sv
// Shared FSM encoding and iteration-counter sizing for the fixpoint iterator.
package fixpoint_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    function automatic int iters_width(input int max_iter);
        return $clog2(max_iter + 1);
    endfunction

endpackage

// File: rtl/fixpoint_step.sv
// One propagation step for a single channel's state vector.
module fixpoint_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] mask,
    input  logic         mode,
    output logic [W-1:0] next,
    output logic         stable
);
    logic [W-1:0] from_below;
    logic [W-1:0] from_above;
    logic [W-1:0] incoming;

    // Masked bits only block new arrivals; a bit already set stays set.
    assign from_below = {cur[W-2:0], 1'b0};
    assign from_above = mode ? {1'b0, cur[W-1:1]} : '0;
    assign incoming   = (from_below | from_above) & ~mask;
    assign next       = cur | incoming;
    assign stable     = (next == cur);

endmodule

// File: rtl/fixpoint_iterator.sv
// Iterates CH channel state vectors in lockstep until all stop changing or MAX_ITER steps elapse.
//   state | meaning
//   IDLE  | waiting for start; results of the previous run held
//   RUN   | one step evaluation per cycle
//   DONE  | one-cycle completion pulse, results valid
module fixpoint_iterator
    import fixpoint_pkg::*;
#(
    parameter int W        = 8,
    parameter int CH       = 4,
    parameter int MAX_ITER = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [CH*W-1:0]                     seed,
    input  logic [CH*W-1:0]                     mask,
    input  logic                                mode,
    output logic                                busy,
    output logic                                done,
    output logic                                fixpoint,
    output logic                                timeout,
    output logic [CH-1:0]                       reach,
    output logic [iters_width(MAX_ITER)-1:0]    iters
);
    localparam int IW = iters_width(MAX_ITER);

    fsm_state_t       fsm;
    logic [CH*W-1:0]  cur_q;
    logic [CH*W-1:0]  mask_q;
    logic             mode_q;
    logic [CH*W-1:0]  next_all;
    logic [CH-1:0]    stable;
    logic [CH-1:0]    reach_final;
    logic [IW-1:0]    iters_inc;

    for (genvar c = 0; c < CH; c++) begin : g_step
        fixpoint_step #(.W(W)) u_step (
            .cur    (cur_q[c*W +: W]),
            .mask   (mask_q[c*W +: W]),
            .mode   (mode_q),
            .next   (next_all[c*W +: W]),
            .stable (stable[c])
        );
    end

    // next_all equals cur_q on convergence, so it is the final state on either exit.
    always_comb begin
        reach_final = '0;
        for (int c = 0; c < CH; c++) begin
            reach_final[c] = next_all[c*W + W - 1];
        end
    end

    assign iters_inc = iters + IW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm      <= IDLE;
            cur_q    <= '0;
            mask_q   <= '0;
            mode_q   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fixpoint <= 1'b0;
            timeout  <= 1'b0;
            reach    <= '0;
            iters    <= '0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        cur_q    <= seed;
                        mask_q   <= mask;
                        mode_q   <= mode;
                        fixpoint <= 1'b0;
                        timeout  <= 1'b0;
                        reach    <= '0;
                        iters    <= '0;
                        busy     <= 1'b1;
                        fsm      <= RUN;
                    end
                end
                RUN: begin
                    iters <= iters_inc;
                    if (&stable) begin
                        fixpoint <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        reach    <= reach_final;
                        fsm      <= DONE;
                    end else begin
                        cur_q <= next_all;
                        if (iters_inc == IW'(MAX_ITER)) begin
                            timeout <= 1'b1;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            reach   <= reach_final;
                            fsm     <= DONE;
                        end
                    end
                end
                DONE: begin
                    fsm <= IDLE;
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixpoint_iterator.sv
// Scoreboard bench: two instances (CH=4/MAX_ITER=16 and CH=1/MAX_ITER=4) driven with shared stimulus.
module tb_fixpoint_iterator;

    typedef struct {
        bit       fp;
        bit       to;
        bit [3:0] reach;
        int       iters;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] seed = '0;
    logic [31:0] mask = '0;
    logic        mode = 1'b0;

    logic        busy_m, done_m, fp_m, to_m;
    logic [3:0]  reach_m;
    logic [4:0]  iters_m;
    logic        busy_s, done_s, fp_s, to_s;
    logic [0:0]  reach_s;
    logic [2:0]  iters_s;

    int checks = 0;
    int errors = 0;
    int dcnt_m = 0;
    int dcnt_s = 0;
    int last_iters = 0;
    exp_t q_main[$];
    exp_t q_small[$];

    always #5 clk = ~clk;

    fixpoint_iterator #(.W(8), .CH(4), .MAX_ITER(16)) u_main (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .mask(mask), .mode(mode),
        .busy(busy_m), .done(done_m), .fixpoint(fp_m), .timeout(to_m),
        .reach(reach_m), .iters(iters_m)
    );

    fixpoint_iterator #(.W(8), .CH(1), .MAX_ITER(4)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed[7:0]), .mask(mask[7:0]), .mode(mode),
        .busy(busy_s), .done(done_s), .fixpoint(fp_s), .timeout(to_s),
        .reach(reach_s), .iters(iters_s)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Lockstep reference: apply the propagation rule bit by bit until nothing changes or the cap hits.
    function automatic exp_t model(input logic [31:0] sd, input logic [31:0] mk,
                                   input logic md, input int nch, input int maxi);
        logic [7:0] cur [4];
        logic [7:0] nxt [4];
        exp_t e;
        int   n;
        bit   same;
        logic lo, hi, prop;
        e.fp = 0; e.to = 0; e.reach = '0; e.iters = 0;
        for (int c = 0; c < 4; c++) begin
            cur[c] = sd[c*8 +: 8];
            nxt[c] = '0;
        end
        n = 0;
        while (1) begin
            n++;
            same = 1;
            for (int c = 0; c < nch; c++) begin
                for (int i = 0; i < 8; i++) begin
                    lo = (i > 0) ? cur[c][i-1] : 1'b0;
                    hi = (i < 7) ? cur[c][i+1] : 1'b0;
                    prop = md ? (lo | hi) : lo;
                    nxt[c][i] = cur[c][i] | (prop & ~mk[c*8 + i]);
                end
                if (nxt[c] != cur[c]) same = 0;
            end
            if (same) begin
                e.fp = 1;
                break;
            end
            for (int c = 0; c < nch; c++) cur[c] = nxt[c];
            if (n == maxi) begin
                e.to = 1;
                break;
            end
        end
        for (int c = 0; c < nch; c++) e.reach[c] = cur[c][7];
        e.iters = n;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done_m) begin
            dcnt_m++;
            if (q_main.size() == 0) begin
                chk("main_unexpected_done", 1, 0);
            end else begin
                e = q_main.pop_front();
                chk("main_fixpoint", int'(fp_m), int'(e.fp));
                chk("main_timeout", int'(to_m), int'(e.to));
                chk("main_reach", int'(reach_m), int'(e.reach));
                chk("main_iters", int'(iters_m), e.iters);
                chk("main_busy_low_at_done", int'(busy_m), 0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done_s) begin
            dcnt_s++;
            if (q_small.size() == 0) begin
                chk("small_unexpected_done", 1, 0);
            end else begin
                e = q_small.pop_front();
                chk("small_fixpoint", int'(fp_s), int'(e.fp));
                chk("small_timeout", int'(to_s), int'(e.to));
                chk("small_reach", int'(reach_s), int'(e.reach[0]));
                chk("small_iters", int'(iters_s), e.iters);
            end
        end
    end

    task automatic run(input logic [31:0] sd, input logic [31:0] mk, input logic md, input bit junk);
        exp_t em, es;
        int cm, cs, budget;
        em = model(sd, mk, md, 4, 16);
        es = model({24'b0, sd[7:0]}, {24'b0, mk[7:0]}, md, 1, 4);
        q_main.push_back(em);
        q_small.push_back(es);
        cm = dcnt_m;
        cs = dcnt_s;
        seed = sd; mask = mk; mode = md; start = 1'b1;
        @(negedge clk);
        chk("busy_after_start", int'(busy_m), 1);
        chk("iters_cleared", int'(iters_m), 0);
        chk("fixpoint_cleared", int'(fp_m), 0);
        if (junk) begin
            // start stays high and inputs move while the run is underway
            seed = $urandom; mask = $urandom; mode = ~md;
            @(negedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        budget = 0;
        while ((dcnt_m == cm || dcnt_s == cs) && budget < 60) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 60) chk("run_done_timeout", budget, 0);
        last_iters = em.iters;
        @(negedge clk);
    endtask

    initial begin
        int budget;
        @(negedge clk);
        chk("reset_busy", int'(busy_m), 0);
        chk("reset_done", int'(done_m), 0);
        chk("reset_fixpoint", int'(fp_m), 0);
        chk("reset_timeout", int'(to_m), 0);
        chk("reset_reach", int'(reach_m), 0);
        chk("reset_iters", int'(iters_m), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run(32'h0000_0001, 32'h0, 1'b0, 1'b0);
        run(32'h0000_0010, 32'h0, 1'b1, 1'b1);
        run(32'h0000_0001, 32'h0000_0010, 1'b0, 1'b0);
        run(32'h1000_8001, 32'h0, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        chk("hold_iters_idle", int'(iters_m), last_iters);
        chk("hold_fixpoint_idle", int'(fp_m), 1);
        chk("hold_reach_idle", int'(reach_m), 4'b1011);

        // Abort a run with reset once two steps have been evaluated.
        seed = 32'h0000_0001; mask = '0; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        budget = 0;
        while (iters_m != 5'd2 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 20) chk("abort_wait_timeout", budget, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy_m), 0);
        chk("abort_done", int'(done_m), 0);
        chk("abort_fixpoint", int'(fp_m), 0);
        chk("abort_timeout", int'(to_m), 0);
        chk("abort_reach", int'(reach_m), 0);
        chk("abort_iters", int'(iters_m), 0);
        chk("abort_small_iters", int'(iters_s), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("abort_still_idle_busy", int'(busy_m), 0);
        chk("abort_still_idle_iters", int'(iters_m), 0);

        for (int k = 0; k < 30; k++) begin
            run($urandom, $urandom & $urandom, 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        chk("main_queue_drained", q_main.size(), 0);
        chk("small_queue_drained", q_small.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fixpoint_iterator.md
FIXPOINT_ITERATOR -- requirements
Module: fixpoint_iterator

Interface
REQ-001 SHALL have parameter W, default 8, meaning bit width of one channel state vector (W >= 2).
REQ-002 SHALL have parameter CH, default 4, meaning number of independent channels iterated in lockstep.
REQ-003 SHALL have parameter MAX_ITER, default 16, meaning the maximum number of step evaluations per run (MAX_ITER >= 1).
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port start  input  1  run request, sampled only in IDLE.
REQ-007 SHALL have port seed  input  CH*W  initial state vectors; channel c occupies bits [c*W +: W].
REQ-008 SHALL have port mask  input  CH*W  per-bit propagation block; same packing as seed.
REQ-009 SHALL have port mode  input  1  0 = forward propagation, 1 = bidirectional propagation.
REQ-010 SHALL have port busy  output  1  high in RUN.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port fixpoint  output  1  last run converged.
REQ-013 SHALL have port timeout  output  1  last run hit MAX_ITER without converging.
REQ-014 SHALL have port reach  output  CH  per channel, bit W-1 of final state.
REQ-015 SHALL have port iters  output  $clog2(MAX_ITER+1)  step evaluations performed in last or current run.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-017 SHALL, in IDLE with start=1, latch seed, mask, mode into internal registers, clear fixpoint, timeout, reach, iters, and enter RUN the next cycle.
REQ-018 SHALL ignore start in RUN and DONE; latched seed/mask/mode are not affected by input changes during a run.
REQ-019 SHALL compute, per channel and bit i, in mode 0: next[i] = cur[i] | (cur[i-1] & ~mask[i]), with cur[-1] = 0.
REQ-020 SHALL compute, in mode 1: next[i] = cur[i] | ((cur[i-1] | cur[i+1]) & ~mask[i]), with cur[-1] = cur[W] = 0.
REQ-021 SHALL perform exactly one step evaluation per RUN cycle and increment iters by one in that cycle.
REQ-022 SHALL, when next == cur for all CH channels, set fixpoint=1, leave state unchanged, and enter DONE.
REQ-023 SHALL otherwise load state <= next; if the incremented iters equals MAX_ITER, set timeout=1 and enter DONE.
REQ-024 SHALL give convergence priority over timeout when both occur on the same evaluation (fixpoint=1, timeout=0).
REQ-025 SHALL, in DONE, drive done=1 for exactly one cycle, update reach from final state, and return to IDLE.
REQ-026 SHALL hold fixpoint, timeout, reach, iters stable in IDLE until the next accepted start.
REQ-027 SHALL never set fixpoint and timeout simultaneously; exactly one is 1 after every completed run.
REQ-028 SHALL preserve seed bits that are set under a masked position (mask blocks only new propagation into that bit).

Reset
REQ-029 SHALL, on rst_n=0 at any time including mid-run, return to IDLE and clear busy, done, fixpoint, timeout, reach, iters and all state registers to 0.
REQ-030 SHALL not produce a done pulse for a run aborted by reset.

Structure
REQ-031 SHALL place the FSM state enum and the iters width function in a shared package fixpoint_pkg.
REQ-032 SHALL implement the per-channel step function in one sub-module fixpoint_step (parameter W; inputs cur, mask, mode; outputs next, stable), instantiated CH times.
REQ-033 SHALL contain no combinational path from start/seed/mask/mode to any output.

Verification (W=8, CH=1 unless stated)
REQ-034 SHALL cover: seed=8'h01, mask=0, mode=0 -> states 03,07,..,FF; done after iters=8, fixpoint=1, reach=1.
REQ-035 SHALL cover: seed=8'h10, mask=0, mode=1 -> 38,7C,FE,FF; iters=5, fixpoint=1, reach=1.
REQ-036 SHALL cover: seed=8'h01, mask=8'h10, mode=0 -> final 8'h0F, iters=4, fixpoint=1, reach=0.
REQ-037 SHALL cover: MAX_ITER=4, seed=8'h01, mask=0, mode=0 -> final 8'h1F, iters=4, timeout=1, fixpoint=0.
REQ-038 SHALL cover: CH=4, seeds {01,80,00,10}, mask=0, mode=0 -> run ends at iters=8 (slowest channel), reach=4'b1011.
REQ-039 SHALL cover: rst_n pulsed low during RUN at iters=2 -> IDLE, all outputs 0, no done; start repeated during RUN ignored.
